// File: rtl/Mem.sv
// Mem: shared memory-word types used by the L1 caches and the memory controller.
//   w_t     : one memory data word
//   waddr_t : word address
package Mem;
  typedef logic [31:0] w_t;
  typedef logic [29:0] waddr_t;
endpackage

// File: rtl/l1cache_mem_arbiter.sv
// l1cache_mem_arbiter
//   Round-robin arbiter that shares one memory server port between N L1 cache
//   clients. Only one transaction is outstanding at a time: the winning request
//   is latched, replayed to the server, and the server response is routed back
//   to the client that owns the transaction.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   c_req_valid/ready    per-client request handshake (ready only while idle)
//   c_req_we/addr/data   per-client request payload
//   c_resp_ack           per-client one-cycle response strobe
//   c_resp_data          response data, broadcast to all clients
//   m_req_valid/ready    request handshake towards the memory server
//   m_req_we/addr/data   registered request payload towards the server
//   m_resp_ack/data      server response strobe and read data
//
// Optional feature (macro L1CACHE_MEM_ARBITER_STATS_EN)
//   stat_grants[N]       saturating per-client grant counters
//   stat_wait[N]         saturating per-client count of cycles spent waiting
module l1cache_mem_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      c_req_valid,
  output logic [N-1:0]      c_req_ready,
  input  logic [N-1:0]      c_req_we,
  input  Mem::waddr_t       c_req_addr [N],
  input  Mem::w_t           c_req_data [N],
  output logic [N-1:0]      c_resp_ack,
  output Mem::w_t           c_resp_data,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic              m_req_we,
  output Mem::waddr_t       m_req_addr,
  output Mem::w_t           m_req_data,
  input  logic              m_resp_ack,
  input  Mem::w_t           m_resp_data
`ifdef L1CACHE_MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]       stat_grants [N],
  output logic [31:0]       stat_wait [N]
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             grant_found;
  logic             accept;
  logic             complete;

  // Round-robin search: start one past the previous winner and wrap modulo N.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= N; k++) begin
      cand_idx = IDX_W'((int'(last) + k) % N);
      if (!grant_found && c_req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_found) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_req_ready) begin
          state_nxt = m_resp_ack ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (m_resp_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode. Ready is masked by rst_n so clients see no acceptance while
  // the block is held in reset.
  always_comb begin
    c_req_ready = '0;
    if (state == ST_IDLE && grant_found && rst_n) begin
      c_req_ready[grant_idx] = 1'b1;
    end
    accept   = (state == ST_IDLE) && grant_found;
    complete = ((state == ST_ISSUE) && m_req_ready && m_resp_ack) ||
               ((state == ST_WAIT) && m_resp_ack);
  end

  // Request latch, server-side valid, and registered completion towards the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last        <= IDX_W'(N - 1);
      owner       <= '0;
      m_req_valid <= 1'b0;
      m_req_we    <= 1'b0;
      m_req_addr  <= '0;
      m_req_data  <= '0;
      c_resp_ack  <= '0;
      c_resp_data <= '0;
    end else begin
      m_req_valid <= (state_nxt == ST_ISSUE);
      c_resp_ack  <= '0;
      if (accept) begin
        owner      <= grant_idx;
        last       <= grant_idx;
        m_req_we   <= c_req_we[grant_idx];
        m_req_addr <= c_req_addr[grant_idx];
        m_req_data <= c_req_data[grant_idx];
      end
      if (complete) begin
        c_resp_ack[owner] <= 1'b1;
        c_resp_data       <= m_resp_data;
      end
    end
  end

`ifdef L1CACHE_MEM_ARBITER_STATS_EN
  // Per-client counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        stat_grants[i] <= '0;
        stat_wait[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (c_req_ready[i] && (stat_grants[i] != 32'hFFFF_FFFF)) begin
          stat_grants[i] <= stat_grants[i] + 32'd1;
        end
        if (c_req_valid[i] && !c_req_ready[i] && (stat_wait[i] != 32'hFFFF_FFFF)) begin
          stat_wait[i] <= stat_wait[i] + 32'd1;
        end
      end
    end
  end
`endif

  // A server ack can only legally arrive while a request is in flight.
  ack_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !((state == ST_IDLE) && m_resp_ack))
    else $error("l1cache_mem_arbiter: m_resp_ack while idle");

  ack_before_accept: assert property (@(posedge clk) disable iff (!rst_n)
    !((state == ST_ISSUE) && m_resp_ack && !m_req_ready))
    else $error("l1cache_mem_arbiter: m_resp_ack before request accepted");

endmodule

// File: tb/tb_l1cache_mem_arbiter.sv
// tb_l1cache_mem_arbiter
//   Directed scenarios (single read, same-cycle ready+ack write, backpressure,
//   reset in flight, round-robin order) followed by a randomized phase in which
//   clients and a memory server are modelled, expected responses are queued at
//   grant time and a separate monitor pops and compares them.
module tb_l1cache_mem_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  c_req_valid;
  logic [N-1:0]  c_req_ready;
  logic [N-1:0]  c_req_we;
  Mem::waddr_t   c_req_addr [N];
  Mem::w_t       c_req_data [N];
  logic [N-1:0]  c_resp_ack;
  Mem::w_t       c_resp_data;
  logic          m_req_valid;
  logic          m_req_ready;
  logic          m_req_we;
  Mem::waddr_t   m_req_addr;
  Mem::w_t       m_req_data;
  logic          m_resp_ack;
  Mem::w_t       m_resp_data;
`ifdef L1CACHE_MEM_ARBITER_STATS_EN
  logic [31:0]   stat_grants [N];
  logic [31:0]   stat_wait [N];
`endif

  l1cache_mem_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_data(c_req_data),
    .c_resp_ack(c_resp_ack), .c_resp_data(c_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_data(m_req_data),
    .m_resp_ack(m_resp_ack), .m_resp_data(m_resp_data)
`ifdef L1CACHE_MEM_ARBITER_STATS_EN
    , .stat_grants(stat_grants), .stat_wait(stat_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    Mem::waddr_t addr;
    Mem::w_t     data;
  } req_t;

  typedef struct {
    int      owner;
    bit      we;
    Mem::w_t data;
  } resp_t;

  int      checks = 0;
  int      failures = 0;
  bit      mon_en = 1'b0;

  // Client / server / reference state for the randomized phase
  bit      has_req [N];
  req_t    pend [N];
  req_t    req_q [$];
  resp_t   resp_q [$];
  Mem::w_t ref_mem [16];
  Mem::w_t srv_mem [16];
  int      rr_last;
  bit      busy;
  bit      srv_busy;
  int      srv_delay;
  req_t    srv_req;
  int      grants [N];
  int      wait_cnt [N];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int idx);
    return N'(1) << idx;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ack(input req_t r);
    m_resp_ack = 1'b1;
    if (r.we) begin
      srv_mem[r.addr[3:0]] = r.data;
      m_resp_data = $urandom;
    end else begin
      m_resp_data = srv_mem[r.addr[3:0]];
    end
  endtask

  // One cycle of randomized server and client behaviour, driven just after posedge.
  task automatic applyStimulus(input bit allow_new);
    req_t r;
    m_resp_ack  = 1'b0;
    m_req_ready = 1'b0;
    if (srv_busy) begin
      checkOutput("req_valid_in_flight", 64'(m_req_valid), 64'd0);
      if (srv_delay == 0) begin
        drive_ack(srv_req);
        srv_busy = 1'b0;
      end else begin
        srv_delay--;
      end
    end else if (m_req_valid) begin
      if (req_q.size() == 0) begin
        checkOutput("req_unexpected", 64'(m_req_valid), 64'd0);
      end else begin
        checkOutput("req_we", 64'(m_req_we), 64'(req_q[0].we));
        checkOutput("req_addr", 64'(m_req_addr), 64'(req_q[0].addr));
        checkOutput("req_data", 64'(m_req_data), 64'(req_q[0].data));
        if ($urandom_range(0, 2) == 0) begin
          m_req_ready = 1'b1;
          void'(req_q.pop_front());
          r.we = m_req_we;
          r.addr = m_req_addr;
          r.data = m_req_data;
          if ($urandom_range(0, 3) == 0) begin
            drive_ack(r);
          end else begin
            srv_busy  = 1'b1;
            srv_delay = $urandom_range(0, 3);
            srv_req   = r;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!has_req[i] && allow_new && ($urandom_range(0, 2) == 0)) begin
        pend[i].we   = $urandom_range(0, 1) == 1;
        pend[i].addr = Mem::waddr_t'($urandom_range(0, 15));
        pend[i].data = $urandom;
        has_req[i]   = 1'b1;
      end
      c_req_valid[i] = has_req[i] && ($urandom_range(0, 7) != 0);
      c_req_we[i]    = pend[i].we;
      c_req_addr[i]  = pend[i].addr;
      c_req_data[i]  = pend[i].data;
    end
  endtask

  // Arbitration reference: while free, the winner is the valid client that is
  // the fewest steps after the previous winner in cyclic order.
  task automatic arb_check();
    int win;
    int best;
    int d;
    logic [N-1:0] exp_ready;
    resp_t e;
    win = -1;
    best = N;
    if (!busy) begin
      for (int c = 0; c < N; c++) begin
        d = (c - rr_last - 1 + N) % N;
        if (c_req_valid[c] && d < best) begin
          best = d;
          win = c;
        end
      end
    end
    exp_ready = (win >= 0) ? onehot(win) : '0;
    checkOutput("arb_ready", 64'(c_req_ready), 64'(exp_ready));
    for (int c = 0; c < N; c++) begin
      if (c_req_valid[c] && !exp_ready[c]) wait_cnt[c]++;
    end
    if (win >= 0) begin
      rr_last = win;
      busy = 1'b1;
      grants[win]++;
      req_q.push_back(pend[win]);
      e.owner = win;
      e.we = pend[win].we;
      e.data = ref_mem[pend[win].addr[3:0]];
      if (pend[win].we) ref_mem[pend[win].addr[3:0]] = pend[win].data;
      resp_q.push_back(e);
      has_req[win] = 1'b0;
    end
    if (busy && m_resp_ack) busy = 1'b0;
  endtask

  // Response monitor: a server ack must be followed next cycle by exactly one
  // strobe to the owner of the oldest outstanding transaction.
  initial begin : monitor
    bit prev_ack;
    resp_t e;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_ack = 1'b0;
      end else begin
        if (prev_ack) begin
          if (resp_q.size() == 0) begin
            checkOutput("resp_unexpected", 64'(c_resp_ack), 64'd0);
          end else begin
            e = resp_q.pop_front();
            checkOutput("resp_ack", 64'(c_resp_ack), 64'(onehot(e.owner)));
            if (!e.we) checkOutput("resp_data", 64'(c_resp_data), 64'(e.data));
          end
        end else begin
          checkOutput("resp_quiet", 64'(c_resp_ack), 64'd0);
        end
        prev_ack = m_resp_ack;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bit done;
    Mem::w_t v;
    rst_n = 1'b0;
    c_req_valid = '0;
    c_req_we = '0;
    for (int i = 0; i < N; i++) begin
      c_req_addr[i] = '0;
      c_req_data[i] = '0;
    end
    m_req_ready = 1'b0;
    m_resp_ack = 1'b0;
    m_resp_data = '0;

    // Reset values, with requests present to show nothing is accepted in reset
    step();
    c_req_valid = 2'b11;
    #1;
    checkOutput("rst_ready", 64'(c_req_ready), 64'd0);
    checkOutput("rst_mvalid", 64'(m_req_valid), 64'd0);
    checkOutput("rst_resp_ack", 64'(c_resp_ack), 64'd0);
    checkOutput("rst_resp_data", 64'(c_resp_data), 64'd0);
    checkOutput("rst_maddr", 64'(m_req_addr), 64'd0);
    c_req_valid = '0;
    step();
    rst_n = 1'b1;

    // Single read from client 1
    step();
    c_req_valid = 2'b10;
    c_req_addr[1] = 30'h10;
    c_req_we[1] = 1'b0;
    #1;
    checkOutput("t1_ready", 64'(c_req_ready), 64'b10);
    step();
    c_req_valid = '0;
    checkOutput("t1_mvalid", 64'(m_req_valid), 64'd1);
    checkOutput("t1_maddr", 64'(m_req_addr), 64'h10);
    checkOutput("t1_mwe", 64'(m_req_we), 64'd0);
    m_req_ready = 1'b1;
    step();
    m_req_ready = 1'b0;
    checkOutput("t1_mvalid_once", 64'(m_req_valid), 64'd0);
    checkOutput("t1_no_ack_a", 64'(c_resp_ack), 64'd0);
    step();
    checkOutput("t1_no_ack_b", 64'(c_resp_ack), 64'd0);
    step();
    checkOutput("t1_no_ack_c", 64'(c_resp_ack), 64'd0);
    m_resp_ack = 1'b1;
    m_resp_data = 32'hDEADBEEF;
    step();
    m_resp_ack = 1'b0;
    checkOutput("t1_resp_ack", 64'(c_resp_ack), 64'b10);
    checkOutput("t1_resp_data", 64'(c_resp_data), 64'hDEADBEEF);
    step();
    checkOutput("t1_ack_pulse", 64'(c_resp_ack), 64'd0);
    checkOutput("t1_data_hold", 64'(c_resp_data), 64'hDEADBEEF);

    // Same-cycle ready+ack write from client 0
    c_req_valid = 2'b01;
    c_req_we[0] = 1'b1;
    c_req_addr[0] = 30'h20;
    c_req_data[0] = 32'h55;
    #1;
    checkOutput("t2_ready", 64'(c_req_ready), 64'b01);
    step();
    c_req_valid = '0;
    checkOutput("t2_mvalid", 64'(m_req_valid), 64'd1);
    checkOutput("t2_mwe", 64'(m_req_we), 64'd1);
    checkOutput("t2_maddr", 64'(m_req_addr), 64'h20);
    checkOutput("t2_mdata", 64'(m_req_data), 64'h55);
    m_req_ready = 1'b1;
    m_resp_ack = 1'b1;
    m_resp_data = 32'h1234;
    step();
    m_req_ready = 1'b0;
    m_resp_ack = 1'b0;
    checkOutput("t2_resp_ack", 64'(c_resp_ack), 64'b01);
    checkOutput("t2_mvalid_off", 64'(m_req_valid), 64'd0);

    // Backpressure: new grant alongside the previous completion, then hold 5 cycles
    c_req_valid = 2'b01;
    c_req_we[0] = 1'b0;
    c_req_addr[0] = 30'h30;
    c_req_data[0] = 32'h77;
    #1;
    checkOutput("t3_ready_b2b", 64'(c_req_ready), 64'b01);
    step();
    c_req_valid = 2'b11;
    c_req_we[1] = 1'b0;
    c_req_addr[1] = 30'h40;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold_valid", 64'(m_req_valid), 64'd1);
      checkOutput("t3_hold_addr", 64'(m_req_addr), 64'h30);
      checkOutput("t3_hold_we", 64'(m_req_we), 64'd0);
      checkOutput("t3_hold_data", 64'(m_req_data), 64'h77);
      checkOutput("t3_no_grant", 64'(c_req_ready), 64'd0);
      step();
    end
    checkOutput("t3_still_valid", 64'(m_req_valid), 64'd1);
    m_req_ready = 1'b1;
    step();
    m_req_ready = 1'b0;
    checkOutput("t3_wait_no_grant", 64'(c_req_ready), 64'd0);
    step();
    m_resp_ack = 1'b1;
    m_resp_data = 32'hCAFEF00D;
    step();
    m_resp_ack = 1'b0;
    checkOutput("t3_resp_ack", 64'(c_resp_ack), 64'b01);
    checkOutput("t3_resp_data", 64'(c_resp_data), 64'hCAFEF00D);
    checkOutput("t3_rr_next", 64'(c_req_ready), 64'b10);
    step();
    c_req_valid = '0;
    checkOutput("t4_maddr", 64'(m_req_addr), 64'h40);
    m_req_ready = 1'b1;
    step();
    m_req_ready = 1'b0;

    // Reset while waiting for the server
    rst_n = 1'b0;
    c_req_valid = 2'b11;
    #1;
    checkOutput("t4_rst_mvalid", 64'(m_req_valid), 64'd0);
    checkOutput("t4_rst_maddr", 64'(m_req_addr), 64'd0);
    checkOutput("t4_rst_resp_data", 64'(c_resp_data), 64'd0);
    checkOutput("t4_rst_ready", 64'(c_req_ready), 64'd0);
    m_resp_ack = 1'b1;
    step();
    m_resp_ack = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checkOutput("t4_no_stale_ack", 64'(c_resp_ack), 64'd0);
    checkOutput("t4_first_grant", 64'(c_req_ready), 64'b01);

    // Round-robin under continuous requests from both clients
    c_req_addr[0] = 30'h100;
    c_req_addr[1] = 30'h200;
    for (int j = 0; j < 4; j++) begin
      checkOutput("rr_grant", 64'(c_req_ready), 64'(onehot(j % 2)));
      step();
      checkOutput("rr_maddr", 64'(m_req_addr), (j % 2 == 1) ? 64'h200 : 64'h100);
      m_req_ready = 1'b1;
      m_resp_ack = 1'b1;
      m_resp_data = 32'hA0 + 32'(j);
      step();
      m_req_ready = 1'b0;
      m_resp_ack = 1'b0;
      checkOutput("rr_owner", 64'(c_resp_ack), 64'(onehot(j % 2)));
      checkOutput("rr_data", 64'(c_resp_data), 64'hA0 + 64'(j));
    end
    c_req_valid = '0;

    // Randomized phase from a fresh reset
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      srv_mem[i] = v;
    end
    for (int i = 0; i < N; i++) begin
      has_req[i] = 1'b0;
      grants[i] = 0;
      wait_cnt[i] = 0;
    end
    rr_last = N - 1;
    busy = 1'b0;
    srv_busy = 1'b0;
    srv_delay = 0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      applyStimulus(1'b1);
      @(negedge clk);
      arb_check();
      step();
    end
    done = 1'b0;
    for (int cyc = 0; cyc < 500 && !done; cyc++) begin
      applyStimulus(1'b0);
      @(negedge clk);
      arb_check();
      done = !busy && (resp_q.size() == 0) && (req_q.size() == 0);
      for (int i = 0; i < N; i++) done = done && !has_req[i];
      if (!done) step();
    end
    checkOutput("drain_complete", 64'(done), 64'd1);
    mon_en = 1'b0;

`ifdef L1CACHE_MEM_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) begin
      checkOutput("stat_grants", 64'(stat_grants[i]), 64'(grants[i]));
      checkOutput("stat_wait", 64'(stat_wait[i]), 64'(wait_cnt[i]));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
